// File: rtl/fixed_point_pkg.sv
// Shared sign-magnitude Q15.16 number format and FSM states for the serial subtractor.
package fixed_point_pkg;

  localparam int unsigned INT_BITS  = 15;
  localparam int unsigned FRAC_BITS = 16;
  localparam int unsigned MAG_BITS  = INT_BITS + FRAC_BITS;
  localparam int unsigned WORD_BITS = MAG_BITS + 1;
  localparam int unsigned CNT_BITS  = 5;

  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MAG_BITS - 1);

  typedef struct packed {
    logic                 sign;
    logic [INT_BITS-1:0]  int_part;
    logic [FRAC_BITS-1:0] frac;
  } fixed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [MAG_BITS-1:0] mag_of(input fixed_t v);
    return {v.int_part, v.frac};
  endfunction

  // A negative zero is folded to +0 so it can never leak into the result sign.
  function automatic fixed_t normalize(input fixed_t v);
    fixed_t r;
    r = v;
    if (mag_of(v) == '0) r.sign = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sumador_serial_bit.sv
// One-bit full adder / subtractor with a registered carry (or borrow) between serial steps.
module sumador_serial_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic sub_i,
  input  logic x_i,
  input  logic y_i,
  output logic sum_c,
  output logic carry_c
);

  logic carry_q;

  assign sum_c   = x_i ^ y_i ^ carry_q;
  assign carry_c = sub_i ? ((~x_i & y_i) | (~(x_i ^ y_i) & carry_q))
                         : ((x_i & y_i) | (carry_q & (x_i ^ y_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     carry_q <= 1'b0;
    else if (clr_i) carry_q <= 1'b0;
    else if (en_i)  carry_q <= carry_c;
  end

endmodule

// File: rtl/resta_punto_fijo_serial.sv
// Bit-serial sign-magnitude Q15.16 subtractor s = a - b, one magnitude bit per cycle.
// RESTA_SATURATE_EN: saturate the magnitude on overflow instead of wrapping.
module resta_punto_fijo_serial
  import fixed_point_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] a,
  input  logic [WORD_BITS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] s,
  output logic                 ovf
);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [MAG_BITS-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic                sub_q, sub_d, sign_q, sign_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  fixed_t              s_q, s_d;

  fixed_t              a_in, b_in;
  logic                sum_c, carry_c;
  logic [MAG_BITS-1:0] mag_fin;
  logic                ovf_fin, sign_fin;

  sumador_serial_bit u_bit (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q != CALC),
    .en_i    (state_q == CALC),
    .sub_i   (sub_q),
    .x_i     (x_q[0]),
    .y_i     (y_q[0]),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Final result as it stands on the last serial step.
  always_comb begin
    mag_fin = {sum_c, r_q[MAG_BITS-1:1]};
    ovf_fin = ~sub_q & carry_c;
`ifdef RESTA_SATURATE_EN
    if (ovf_fin) mag_fin = '1;
`else
    mag_fin = mag_fin;
`endif
    sign_fin = (mag_fin == '0) ? 1'b0 : sign_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sub_d   = sub_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    s_d     = s_q;
    a_in    = normalize(fixed_t'(a));
    b_in    = normalize(fixed_t'(b));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PREP;
          busy_d  = 1'b1;
          x_d     = mag_of(a_in);
          y_d     = mag_of(b_in);
          sa_d    = a_in.sign;
          sb_d    = ~b_in.sign;
        end
      end
      PREP: begin
        // Subtraction always runs larger minus smaller so the borrow never escapes.
        sub_d  = sa_q ^ sb_q;
        sign_d = sa_q;
        if ((sa_q ^ sb_q) && (y_q > x_q)) begin
          x_d    = y_q;
          y_d    = x_q;
          sign_d = sb_q;
        end
        cnt_d   = '0;
        r_d     = '0;
        state_d = CALC;
      end
      CALC: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        r_d   = {sum_c, r_q[MAG_BITS-1:1]};
        cnt_d = CNT_BITS'(cnt_q + 1'b1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          s_d     = fixed_t'({sign_fin, mag_fin});
          ovf_d   = ovf_fin;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sub_q   <= sub_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      s_q     <= s_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = WORD_BITS'(s_q);
  assign ovf  = ovf_q;

endmodule

// File: doc/resta_punto_fijo_serial.md
RESTA_PUNTO_FIJO_SERIAL -- requirements
Module: resta_punto_fijo_serial

Interface
REQ-001 The block SHALL have no parameters; the number format comes from the shared package (sign-magnitude Q15.16, 32 bits).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  minuend: bit 31 sign, [30:16] integer, [15:0] fraction.
REQ-006 b  input  32  subtrahend, same format.
REQ-007 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-008 done  output  1  one-cycle pulse; s and ovf are valid from this cycle.
REQ-009 s  output  32  result a - b, same format.
REQ-010 ovf  output  1  magnitude overflow of the current result.

Function
REQ-011 The block SHALL compute s = a - b as sign-magnitude: invert b's sign, then add or subtract magnitudes.
REQ-012 FSM states SHALL be IDLE, PREP, CALC and DONE.
- IDLE->PREP on start.
- PREP->CALC after one cycle.
- CALC->DONE after 31 cycles.
- DONE->IDLE after one cycle.
REQ-013 On accept, a and b SHALL be latched; later input changes do not affect the result.
REQ-014 PREP SHALL compare magnitudes and select the operation (add if effective signs are equal, else larger minus smaller).
REQ-015 CALC SHALL process one magnitude bit per cycle, LSB first, using a registered carry or borrow, under a 5-bit counter from 0 to 30.
REQ-016 Result sign:
- Equal effective signs: the common sign.
- Different effective signs: the sign of the larger magnitude.
- Zero magnitude: always 0 (no negative zero).
REQ-017 Inputs with zero magnitude and sign 1 SHALL be treated as +0.
REQ-018 done SHALL be high exactly 33 cycles after the edge that samples start.
REQ-019 s and ovf SHALL update only when DONE is entered, and hold until the next DONE.
REQ-020 ovf SHALL be set when a magnitude addition carries out of bit 30; it is cleared for every other result.
REQ-021 start while busy SHALL be ignored, with no queuing; start in the DONE cycle is also ignored.
REQ-022 A new start in IDLE the cycle after DONE SHALL be accepted, giving back-to-back operation every 34 cycles.

Reset
REQ-023 On rst_n low, asynchronously:
- state=IDLE.
- busy=0, done=0, s=32'h0, ovf=0.
- counter, carry and latched operands cleared.
REQ-024 Reset during PREP/CALC/DONE SHALL abort the operation; no done pulse is produced for it.

Configuration
REQ-025 Macro RESTA_SATURATE_EN SHALL control overflow handling.
- Defined: on overflow, the magnitude saturates to 31'h7FFFFFFF while keeping the result sign.
- Undefined: the magnitude wraps modulo 2^31.
- In both cases ovf=1 on overflow.

Structure
REQ-026 Package fixed_point_pkg SHALL hold:
- typedef fixed_t (32-bit packed struct: sign, int[14:0], frac[15:0]).
- INT_BITS=15, FRAC_BITS=16, MAG_BITS=31.
- The FSM state enum.
REQ-027 One sub-module, sumador_serial_bit, SHALL implement the 1-bit full adder/subtractor with registered carry/borrow, clear and enable.

Verification
REQ-028 a=0x00034000 (3.25), b=0x00018000 (1.5) -> done at cycle 33, s=0x0001C000, ovf=0.
REQ-029 a=0x00018000, b=0x00034000 -> s=0x8001C000 (-1.75); then a=0x00018000, b=0x80034000 -> s=0x0004C000 (4.75).
REQ-030 a=b=0x00018000 -> s=0x00000000; a=0x80000000, b=0x00000000 -> s=0x00000000, sign 0.
REQ-031 a=0x7FFF0000, b=0x80010000 -> ovf=1; s=0x7FFFFFFF with RESTA_SATURATE_EN, s=0x00000000 without it.
REQ-032 Second start pulse at cycle 5 with new operands -> ignored, first result unchanged; start at cycle 34 -> accepted.
REQ-033 rst_n low at cycle 10 of an operation -> busy=0, s=0 immediately, no done pulse; the next start completes normally.
